// File: rtl/pipelined_adder_pkg.sv
// Shared constants and helpers for the pipelined adder.
// Default operand width, legal pipeline depths, and the signed saturation limits.
package pipelined_adder_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_STAGES = 2;

    // Pipeline depths the chunked carry chain supports
    localparam int LEGAL_STAGES [3] = '{1, 2, 4};

    // Returns 1 when the requested depth is one of the supported values
    function automatic bit stages_legal(input int stages);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (LEGAL_STAGES[i] == stages) begin
                ok = 1'b1;
            end
        end
        return ok;
    endfunction

    // Largest positive two's-complement value of the given width, zero-extended to 64 bits
    function automatic logic [63:0] signed_max(input int width);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < width - 1; i++) begin
            v[i] = 1'b1;
        end
        return v;
    endfunction

    // Most negative two's-complement value of the given width, zero-extended to 64 bits
    function automatic logic [63:0] signed_min(input int width);
        logic [63:0] v;
        v = '0;
        v[width-1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/pipelined_adder_chunk.sv
// One slice of the carry chain: a CW-bit adder with carry in/out.
// Also reports the signed-overflow term for this slice; only the most
// significant slice's term is meaningful for the whole word.
module adder_chunk #(
    parameter int CW = 16
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout,
    output logic          ovf
);

    // Plain ripple add; the extra top bit captures the carry out
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
        ovf         = (a[CW-1] == b[CW-1]) && (sum[CW-1] != a[CW-1]);
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit with a valid/ready handshake on both sides.
// The word is split into STAGES chunks; each pipeline stage adds one chunk
// using the carry registered by the previous stage, least significant first.
// Optional feature: define PIPELINED_ADDER_SAT_EN to add the 'sat' input and
// signed saturation of the result on overflow.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sub,
`ifdef PIPELINED_ADDER_SAT_EN
    input  logic             sat,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             ovf,
    output logic             zero,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW = WIDTH / STAGES;

`ifdef PIPELINED_ADDER_SAT_EN
    localparam logic [63:0]      SMAX64 = signed_max(WIDTH);
    localparam logic [63:0]      SMIN64 = signed_min(WIDTH);
    localparam logic [WIDTH-1:0] SMAX   = SMAX64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SMIN   = SMIN64[WIDTH-1:0];
`endif

    // Per-stage registers: operands travel with the partial sum so that
    // later stages still have the upper chunks they have yet to add.
    logic             valid_q [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic             carry_q [STAGES];
    logic             ovf_q;
    logic             zero_q;

    logic             valid_d [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] b_d     [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
    logic             carry_d [STAGES];
    logic             ovf_d;
    logic             zero_d;

`ifdef PIPELINED_ADDER_SAT_EN
    logic             sat_q   [STAGES];
    logic             sat_d   [STAGES];
`endif

    logic             adv;

    // The whole pipe moves as one; it only stalls when a finished result is not taken
    assign adv       = !valid_q[STAGES-1] || out_ready;
    assign in_ready  = adv;

    assign out       = sum_q[STAGES-1];
    assign carry     = carry_q[STAGES-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign out_valid = valid_q[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] sum_in;
        logic [WIDTH-1:0] sum_merged;
        logic             valid_in;
        logic             cin;
        logic [CW-1:0]    chunk_sum;
        logic             chunk_cout;
        logic             chunk_ovf;
`ifdef PIPELINED_ADDER_SAT_EN
        logic             sat_in;
`endif

        if (k == 0) begin : g_first
            // Subtraction is folded in up front as in1 + ~in2 + 1
            assign valid_in = in_valid;
            assign a_in     = in1;
            assign b_in     = sub ? ~in2 : in2;
            assign cin      = sub;
            assign sum_in   = '0;
`ifdef PIPELINED_ADDER_SAT_EN
            assign sat_in   = sat;
`endif
        end else begin : g_next
            assign valid_in = valid_q[k-1];
            assign a_in     = a_q[k-1];
            assign b_in     = b_q[k-1];
            assign cin      = carry_q[k-1];
            assign sum_in   = sum_q[k-1];
`ifdef PIPELINED_ADDER_SAT_EN
            assign sat_in   = sat_q[k-1];
`endif
        end

        adder_chunk #(
            .CW(CW)
        ) u_chunk (
            .a    (a_in[k*CW +: CW]),
            .b    (b_in[k*CW +: CW]),
            .cin  (cin),
            .sum  (chunk_sum),
            .cout (chunk_cout),
            .ovf  (chunk_ovf)
        );

        // Drop this stage's chunk into the partially completed result
        always_comb begin
            sum_merged              = sum_in;
            sum_merged[k*CW +: CW]  = chunk_sum;
        end

        assign valid_d[k] = valid_in;
        assign a_d[k]     = a_in;
        assign b_d[k]     = b_in;
        assign carry_d[k] = chunk_cout;
`ifdef PIPELINED_ADDER_SAT_EN
        assign sat_d[k]   = sat_in;
`endif

        if (k == STAGES - 1) begin : g_last
            logic [WIDTH-1:0] final_sum;
`ifdef PIPELINED_ADDER_SAT_EN
            // Clamp toward the sign of the operands when the signed result wrapped
            always_comb begin
                final_sum = sum_merged;
                if (sat_in && chunk_ovf) begin
                    final_sum = a_in[WIDTH-1] ? SMIN : SMAX;
                end
            end
`else
            assign final_sum = sum_merged;
`endif
            assign sum_d[k] = final_sum;
            assign ovf_d    = chunk_ovf;
            assign zero_d   = (final_sum == '0);
        end else begin : g_mid
            assign sum_d[k] = sum_merged;
        end
    end

    // Pipeline register bank: reset clears everything, otherwise shift on advance
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                sum_q[k]   <= '0;
                carry_q[k] <= 1'b0;
`ifdef PIPELINED_ADDER_SAT_EN
                sat_q[k]   <= 1'b0;
`endif
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= valid_d[k];
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
                sum_q[k]   <= sum_d[k];
                carry_q[k] <= carry_d[k];
`ifdef PIPELINED_ADDER_SAT_EN
                sat_q[k]   <= sat_d[k];
`endif
            end
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=32, STAGES=2).
// Builds with or without PIPELINED_ADDER_SAT_EN.
module tb_pipelined_adder;

    localparam int W = 32;
    localparam int S = 2;

    typedef struct packed {
        logic [W-1:0] out;
        logic         carry;
        logic         ovf;
        logic         zero;
    } result_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         sub;
`ifdef PIPELINED_ADDER_SAT_EN
    logic         sat;
`endif
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out;
    logic         carry;
    logic         ovf;
    logic         zero;
    logic         out_valid;
    logic         out_ready;

    result_t sb_q[$];
    int      n_vec;
    int      n_bad;

    pipelined_adder #(
        .WIDTH  (W),
        .STAGES (S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in1       (in1),
        .in2       (in2),
        .sub       (sub),
`ifdef PIPELINED_ADDER_SAT_EN
        .sat       (sat),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .carry     (carry),
        .ovf       (ovf),
        .zero      (zero),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer add/subtract with signed range test
    function automatic result_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic s, input logic sat_i);
        result_t      r;
        longint       sa;
        longint       sb;
        longint       sr;
        longint       mx;
        longint       mn;
        logic [W:0]   wide;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        mx = (longint'(1) <<< (W - 1)) - 1;
        mn = -mx - 1;
        sr = s ? sa - sb : sa + sb;
        wide = {1'b0, a} + {1'b0, b};
        r.out   = s ? a - b : a + b;
        r.carry = s ? (a >= b) : wide[W];
        r.ovf   = (sr > mx) || (sr < mn);
        if (sat_i && r.ovf) begin
            r.out = (sr > 0) ? W'(mx) : W'(mn);
        end
        r.zero  = (r.out == '0);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of input drive; reports whether the operation was accepted
    task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input logic sat_i, output logic acc);
        logic r;
        in_valid = v;
        in1      = a;
        in2      = b;
        sub      = s;
`ifdef PIPELINED_ADDER_SAT_EN
        sat      = sat_i;
`endif
        @(negedge clk);
        r = in_ready;
        @(posedge clk);
        acc = v && r;
        if (acc) sb_q.push_back(model(a, b, s, sat_i));
        #1;
    endtask

    task automatic sendOp(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic sat_i);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 100) begin
            applyStimulus(1'b1, a, b, s, sat_i, acc);
            tries++;
        end
        if (!acc) checkOutput("accept_timeout", {63'd0, acc}, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(7))
            0:       return '0;
            1:       return '1;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h0000_FFFF;
            default: return W'($urandom);
        endcase
    endfunction

    function automatic logic rnd_sat();
`ifdef PIPELINED_ADDER_SAT_EN
        return 1'($urandom_range(1));
`else
        return 1'b0;
`endif
    endfunction

    // Monitor: pops the scoreboard on every consumed result, checks hold-while-stalled
    initial begin : monitor
        result_t act;
        result_t exp;
        result_t held;
        logic    hold_pending;
        hold_pending = 1'b0;
        held         = '0;
        forever begin
            @(negedge clk);
            act = {out, carry, ovf, zero};
            if (rst) begin
                hold_pending = 1'b0;
            end else begin
                if (hold_pending) begin
                    checkOutput("hold_valid", {63'd0, out_valid}, 64'd1);
                    checkOutput("hold_data", 64'(act), 64'(held));
                end
                checkOutput("in_ready_rule", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        checkOutput("unexpected_output", {63'd0, out_valid}, 64'd0);
                    end else begin
                        exp = sb_q.pop_front();
                        checkOutput("result", 64'(act), 64'(exp));
                    end
                end
                hold_pending = out_valid && !out_ready;
                held         = act;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic acc;
        int   lat;
        int   n_acc;
        n_vec     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in1       = '0;
        in2       = '0;
        sub       = 1'b0;
        out_ready = 1'b1;
`ifdef PIPELINED_ADDER_SAT_EN
        sat       = 1'b0;
`endif

        // Reset state
        @(posedge clk);
        #1;
        checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_out", 64'(out), 64'd0);
        checkOutput("rst_flags", {61'd0, carry, ovf, zero}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("post_rst_out_valid", {63'd0, out_valid}, 64'd0);

        // All-ones plus one wraps to zero with carry; latency check
        sendOp(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("latency", 64'(lat), 64'(S));
        idle(S + 1);

        // Signed overflow, then subtract with borrow
        sendOp(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
`ifdef PIPELINED_ADDER_SAT_EN
        sendOp(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1);
        sendOp(32'h8000_0000, 32'd1, 1'b1, 1'b1);
`endif
        sendOp(32'd5, 32'd7, 1'b1, 1'b0);
        idle(S + 2);

        // Eight back-to-back operations
        for (int j = 0; j < 8 + S - 1; j++) begin
            if (j < 8) begin
                applyStimulus(1'b1, rnd_op(), rnd_op(), 1'($urandom_range(1)), rnd_sat(), acc);
                checkOutput("b2b_accept", {63'd0, acc}, 64'd1);
            end else begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            checkOutput("b2b_out_valid", {63'd0, out_valid}, {63'd0, (j >= S - 1)});
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("b2b_done", {63'd0, out_valid}, 64'd0);

        // Output stall with inputs offered
        idle(S + 2);
        out_ready = 1'b0;
        n_acc     = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, rnd_op(), rnd_op(), 1'($urandom_range(1)), rnd_sat(), acc);
            if (acc) n_acc++;
        end
        checkOutput("stall_in_ready", {63'd0, in_ready}, 64'd0);
        checkOutput("stall_accepted", 64'(n_acc), 64'(S));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(S + 2);
        checkOutput("stall_drained", 64'(sb_q.size()), 64'd0);

        // Reset with two operations in flight
        out_ready = 1'b0;
        applyStimulus(1'b1, rnd_op(), rnd_op(), 1'b0, 1'b0, acc);
        applyStimulus(1'b1, rnd_op(), rnd_op(), 1'b1, 1'b0, acc);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        sb_q.delete();
        #1;
        checkOutput("rst_flush_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_flush_in_ready", {63'd0, in_ready}, 64'd1);
        rst       = 1'b0;
        out_ready = 1'b1;
        idle(S + 6);
        checkOutput("rst_no_stale", {63'd0, out_valid}, 64'd0);

        // Random traffic with random back-pressure
        for (int i = 0; i < 300; i++) begin
            out_ready = ($urandom_range(3) != 0);
            applyStimulus(1'($urandom_range(1)), rnd_op(), rnd_op(),
                          1'($urandom_range(1)), rnd_sat(), acc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 50 && sb_q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("final_drain", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand and result width in bits; legal values are multiples of STAGES, 8..64.
REQ-002 SHALL have parameter STAGES, default 2, the pipeline depth and number of carry-chain chunks; legal values are 1, 2, 4.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports in1 and in2, input, WIDTH bits each: the operands.
REQ-006 SHALL have port sub, input, 1 bit: 0 selects in1+in2, 1 selects in1-in2.
REQ-007 SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit): the operand handshake.
REQ-008 SHALL have port out, output, WIDTH bits: the result.
REQ-009 SHALL have port carry, output, 1 bit: unsigned carry-out; for subtract it is 1 when no borrow occurs.
REQ-010 SHALL have port ovf, output, 1 bit: signed two's-complement overflow.
REQ-011 SHALL have port zero, output, 1 bit: set when out equals 0.
REQ-012 SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): the result handshake.

Function
REQ-013 SHALL accept an operation on a rising edge where in_valid and in_ready are both 1.
REQ-014 SHALL compute in1 + (sub ? ~in2 : in2) + sub modulo 2^WIDTH.
REQ-015 SHALL split operands into STAGES chunks of WIDTH/STAGES bits; stage k adds chunk k plus the registered carry from stage k-1, least significant chunk first.
REQ-016 SHALL carry the not-yet-added upper operand chunks and the completed lower result chunks forward through the pipeline registers.
REQ-017 SHALL present the result with out_valid=1 exactly STAGES cycles after acceptance when out_ready is held 1.
REQ-018 SHALL use a global advance enable, adv = !out_valid || out_ready; all stages shift only when adv=1.
REQ-019 SHALL drive in_ready = adv, combinationally.
REQ-020 SHALL hold out, its flags and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL carry a valid bit in every stage; bubbles propagate as valid=0 and SHALL NOT produce out_valid.
REQ-022 SHALL sustain back-to-back throughput of one operation per cycle with out_ready=1.
REQ-023 SHALL compute ovf as (msb(in1) == msb(effective in2)) && (msb(out) != msb(in1)).
REQ-024 SHALL register carry, ovf and zero alongside out and keep them aligned with it.
REQ-025 SHALL, when a new input is accepted in the same cycle the final result is consumed, take the new input without a bubble.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, clear all stage valid bits, out_valid, out, carry, ovf and zero to 0.
REQ-027 SHALL discard in-flight operations on reset mid-operation; none SHALL appear afterwards.
REQ-028 SHALL drive in_ready to 1 during and immediately after reset.

Configuration
REQ-029 SHALL, when macro PIPELINED_ADDER_SAT_EN is defined, add input port sat (1 bit, pipelined with its operation); sat=1 with ovf=1 SHALL clamp out to the signed maximum (positive overflow) or the signed minimum (negative overflow), with ovf still reported.
REQ-030 SHALL, without PIPELINED_ADDER_SAT_EN, omit port sat and the clamp logic, so out always wraps.

Structure
REQ-031 SHALL place the default WIDTH, the legal STAGES values and the signed max/min constant functions in a shared package, pipelined_adder_pkg.
REQ-032 SHALL instantiate one sub-module, adder_chunk: a combinational (WIDTH/STAGES)-bit adder with carry-in and carry-out and with the chunk's signed-overflow term, one instance per stage.

Verification
REQ-033 SHALL cover: WIDTH=32, STAGES=2, in1=0xFFFFFFFF, in2=1, sub=0 -> out=0, carry=1, zero=1, ovf=0, out_valid 2 cycles after acceptance.
REQ-034 SHALL cover: in1=0x7FFFFFFF, in2=1, sub=0 -> out=0x80000000, ovf=1, carry=0; with SAT_EN and sat=1 -> out=0x7FFFFFFF, ovf=1.
REQ-035 SHALL cover: in1=5, in2=7, sub=1 -> out=0xFFFFFFFE, carry=0, ovf=0.
REQ-036 SHALL cover: 8 back-to-back operations with out_ready=1 -> 8 results in order on consecutive cycles, in_ready constantly 1.
REQ-037 SHALL cover: out_ready=0 for 5 cycles while inputs are offered -> in_ready=0 once the pipe is full, out held stable, no loss or duplication after release.
REQ-038 SHALL cover: rst asserted with 2 operations in flight -> out_valid=0 the next cycle, and no stale result ever emitted.
